// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration path.
// ROM marker codes and the sequencer FSM state encoding.
package ov7670_pkg;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        DRAIN,
        DELAY,
        FINISH,
        DONE
    } state_e;

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Command handshake between the config sequencer and the SCCB master.
// The master side presents a register write; the slave side accepts it.
interface ov7670_config_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_reg,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_reg,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/delay_counter.sv
// Free-running delay counter with synchronous clear and count enable.
// tc is high while the count sits on its last value (DELAY_CYCLES-1).
module delay_counter #(
    parameter int DELAY_CYCLES = 2_500_000,
    parameter int CNT_W        = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on load, otherwise step when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(DELAY_CYCLES - 1));

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB write per entry.
// FFF0 entries insert a fixed delay; FFFF (or address FF) ends the table.
module ov7670_config_sequencer #(
    parameter logic [7:0] START_ADDR   = 8'd0,
    parameter int         DELAY_CYCLES = 2_500_000,
    parameter int         CNT_W        = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [7:0]                 rom_addr,
    input  logic [15:0]                rom_dout,
    ov7670_config_sequencer_if.master  cmd,
    output logic                       busy,
    output logic                       done
);

    import ov7670_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] rom_addr_q, rom_addr_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_reg_q, cmd_reg_d;
    logic [7:0] cmd_data_q, cmd_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dly_load;
    logic       dly_en;
    logic       dly_tc;
    logic       last_entry;

    // Address FF is the last slot; consuming it ends the table.
    assign last_entry = (rom_addr_q == 8'hFF);

    delay_counter #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .CNT_W        (CNT_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .load (dly_load),
        .en   (dly_en),
        .tc   (dly_tc)
    );

    // State, address and command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= START_ADDR;
            cmd_valid_q <= 1'b0;
            cmd_reg_q   <= 8'd0;
            cmd_data_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_dout == ROM_END) begin
                    state_d = FINISH;
                end else if (rom_dout == ROM_DELAY) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cmd.cmd_ready) begin
                    state_d = last_entry ? FINISH : FETCH;
                end
            end
            DRAIN: begin
                if (cmd.cmd_ready) state_d = DELAY;
            end
            DELAY: begin
                if (dly_tc) begin
                    state_d = last_entry ? FINISH : FETCH;
                end
            end
            FINISH: begin
                if (cmd.cmd_ready) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath updates per state.
    always_comb begin
        rom_addr_d  = rom_addr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_data_d  = cmd_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        dly_load    = 1'b0;
        dly_en      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rom_addr_d = START_ADDR;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            DECODE: begin
                if (rom_dout != ROM_END && rom_dout != ROM_DELAY) begin
                    cmd_reg_d   = rom_dout[15:8];
                    cmd_data_d  = rom_dout[7:0];
                    cmd_valid_d = 1'b1;
                end
            end
            SEND: begin
                if (cmd.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (!last_entry) rom_addr_d = rom_addr_q + 8'd1;
                end
            end
            DRAIN: begin
                dly_load = cmd.cmd_ready;
            end
            DELAY: begin
                dly_en = 1'b1;
                if (dly_tc && !last_entry) rom_addr_d = rom_addr_q + 8'd1;
            end
            FINISH: begin
                if (cmd.cmd_ready) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rom_addr     = rom_addr_q;
    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_reg   = cmd_reg_q;
    assign cmd.cmd_data  = cmd_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
